// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 2-flop sync, start-edge detect, mid-bit sampling of data/parity/stop.
// Latency: status pulses one clock after the mid-stop-bit sample (CLKS_PER_BIT/2 + (DATA_BITS+PARITY_EN+1)*CLKS_PER_BIT + 1 from START).
// Backpressure: none; the line cannot be stalled, so results are single-cycle pulses and data_out is held until the next frame.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 rx_in,
    output logic                 strt_bit,
    output logic                 busy,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s, rx_prev;
    logic                 fall;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        idx, idx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 mismatch, mismatch_nxt;
    logic [DATA_BITS-1:0] data_out_nxt;
    logic                 strt_nxt, dv_nxt, pe_nxt, fe_nxt;

    // Line idles high, so the synchroniser and history flop reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;
    assign busy = (state != IDLE);

    // State, timing counters, shift register and registered status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            mismatch   <= 1'b0;
            data_out   <= '0;
            strt_bit   <= 1'b0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shreg      <= shreg_nxt;
            mismatch   <= mismatch_nxt;
            data_out   <= data_out_nxt;
            strt_bit   <= strt_nxt;
            data_valid <= dv_nxt;
            parity_err <= pe_nxt;
            frame_err  <= fe_nxt;
        end
    end

    // Next-state and sampling decisions; every sample is taken at a counter terminal count.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        shreg_nxt    = shreg;
        mismatch_nxt = mismatch;
        data_out_nxt = data_out;
        strt_nxt     = 1'b0;
        dv_nxt       = 1'b0;
        pe_nxt       = 1'b0;
        fe_nxt       = 1'b0;
        case (state)
            IDLE: begin
                // Edge is only honoured while armed; it is not latched for later.
                if (fall && enable) begin
                    state_nxt    = START;
                    cnt_nxt      = '0;
                    mismatch_nxt = 1'b0;
                end
            end
            START: begin
                if (cnt == HALF_TC) begin
                    if (!rx_s) begin
                        strt_nxt  = 1'b1;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                        state_nxt = DATA;
                    end else begin
                        // Line already back high at mid-bit: treat as a glitch.
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_TC) begin
                    cnt_nxt        = '0;
                    shreg_nxt[idx] = rx_s;
                    if (idx == LAST_IDX) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (cnt == FULL_TC) begin
                    cnt_nxt      = '0;
                    mismatch_nxt = rx_s ^ (^shreg) ^ ODD;
                    state_nxt    = STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == FULL_TC) begin
                    cnt_nxt      = '0;
                    data_out_nxt = shreg;
                    state_nxt    = IDLE;
                    if (rx_s) begin
                        dv_nxt = 1'b1;
                        pe_nxt = mismatch;
                    end else begin
                        fe_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART. It replaces the asynchronous edge-triggered start detector with a fully synchronous controller.
- Synchronises rx_in and detects the start edge when armed by the top-level FSM.
- Validates the start bit at mid-bit and times the sampling of data, optional parity and stop bits.
- Delivers the received byte with status pulses to the top-level FSM / host interface.

Parameters:
CLKS_PER_BIT, 868, system clocks per bit period (>=4, even); counter width is $clog2(CLKS_PER_BIT).
DATA_BITS, 8, data bits per frame (5..8), LSB first.
PARITY_EN, 0, 1 = one parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  reset, asynchronous, active-high.
enable  input  1  from top FSM; arms start detection while high.
rx_in  input  1  asynchronous serial line, idle high.
strt_bit  output  1  one-clock pulse when a start bit is validated at mid-bit.
busy  output  1  high whenever state != IDLE.
data_out  output  DATA_BITS  last received data word, held until next frame completes.
data_valid  output  1  one-clock pulse, frame received with good stop bit.
parity_err  output  1  one-clock pulse coincident with data_valid when parity mismatches.
frame_err  output  1  one-clock pulse when the stop bit samples low.

Behaviour:
Reset values:
- strt_bit=0, busy=0, data_out=0, data_valid=0, parity_err=0, frame_err=0.
- Synchroniser flops and previous-sample flop reset to 1.
- State resets to IDLE; bit counter and bit index reset to 0.

Synchroniser and edge detect:
- rx_in passes through a 2-flop synchroniser giving rx_s.
- Falling edge = previous rx_s 1, current rx_s 0.
- All sampling below uses rx_s.

States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on falling edge and enable=1 -> START, counter=0. A falling edge with enable=0 is ignored and not remembered.
- START: counter counts 0..CLKS_PER_BIT/2-1. At terminal count, sample rx_s:
  - 0: pulse strt_bit, counter=0, index=0 -> DATA.
  - 1: glitch; -> IDLE, no status pulses.
- DATA: counter counts 0..CLKS_PER_BIT-1. At terminal count, sample rx_s into shift register bit[index] (LSB first) and clear counter.
  - After DATA_BITS samples -> PARITY if PARITY_EN, else -> STOP.
- PARITY: at terminal count, sample the parity bit. Expected value = XOR of data bits, inverted if PARITY_ODD. Store mismatch flag -> STOP.
- STOP: at terminal count, sample rx_s, load data_out with the shift register (always) -> IDLE.
  - rx_s=1: pulse data_valid; pulse parity_err if the mismatch flag is set.
  - rx_s=0: pulse frame_err only; no data_valid, no parity_err.
- Status pulses are registered and assert in the cycle after the stop sample, i.e. the first IDLE cycle.

Boundary conditions:
- Latency: with the first START cycle as cycle 1, data_valid asserts at cycle CLKS_PER_BIT/2 + (DATA_BITS + PARITY_EN + 1) * CLKS_PER_BIT + 1.
- Deasserting enable mid-frame does not abort; the frame completes normally.
- After a frame error with the line held low, there is no retrigger until rx_s returns high and falls again (edge-based).
- A start edge arriving in the first IDLE cycle after STOP is accepted (back-to-back frames).
- Reset asserted mid-frame returns immediately to reset values and discards the partial frame.
- The mismatch flag is cleared on entry to START.

Test Plan:
1. CLKS_PER_BIT=8, DATA_BITS=8, no parity, enable=1, send 0xA5 with stop=1 -> one strt_bit pulse; data_valid single pulse 77 clocks after START entry; data_out=0xA5; parity_err=0, frame_err=0; busy low afterwards.
2. Glitch: rx_in low for 2 clocks then high, enable=1 -> busy pulses high <=4 clocks then returns to IDLE; strt_bit, data_valid and frame_err stay 0; data_out unchanged.
3. Frame error: send 0x3C with stop=0, hold line low 40 clocks, then high, then send 0x5A correctly -> frame_err single pulse, data_valid=0, data_out=0x3C; no retrigger while low; then data_valid with data_out=0x5A.
4. PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity=0 -> data_valid and parity_err pulse together, data_out=0x07. Resend 0x07 with parity=1 -> data_valid only.
5. enable=0 during a falling edge -> no busy, no outputs. Then enable=1, start frame 0x81 and drop enable after strt_bit -> frame completes, data_valid with data_out=0x81.
6. Back-to-back 0x11 then 0xEE with zero idle gap -> two data_valid pulses, correct data each. Then reset asserted mid-third-frame at DATA bit 3 -> all outputs 0 immediately, busy=0, next clean frame 0x42 received correctly.
